// File: rtl/rob_nway_pkg.sv
// Shared types for the N-way reorder buffer.
// Entry record and dispatch/retire packets for future port bundling.
package rob_nway_pkg;

  localparam int ROB_AREG_W = 5;
  localparam int ROB_PREG_W = 6;
  localparam int ROB_PC_W   = 32;

  typedef struct packed {
    logic                  valid;
    logic                  complete;
    logic                  mispredict;
    logic [ROB_PC_W-1:0]   target_pc;
    logic [ROB_AREG_W-1:0] areg;
    logic [ROB_PREG_W-1:0] preg;
    logic [ROB_PREG_W-1:0] old_preg;
  } ROB_ENTRY;

  typedef struct packed {
    logic                  valid;
    logic [ROB_AREG_W-1:0] dest_areg;
    logic [ROB_PREG_W-1:0] dest_preg;
    logic [ROB_PREG_W-1:0] old_preg;
  } ROB_DP_PACKET;

  typedef struct packed {
    logic                  valid;
    logic [ROB_AREG_W-1:0] dest_areg;
    logic [ROB_PREG_W-1:0] dest_preg;
    logic [ROB_PREG_W-1:0] old_preg;
  } ROB_RT_PACKET;

endpackage

// File: rtl/rob_retire_sel.sv
// Retire prefix scan over the WAY oldest ROB entries.
// Stops at the first not-ready entry or just after a mispredict.
module rob_retire_sel
  import rob_nway_pkg::*;
#(
  parameter  int WAY = 2,
  localparam int NW  = $clog2(WAY + 1)
) (
  input  logic [WAY-1:0] valid_i,
  input  logic [WAY-1:0] complete_i,
  input  logic [WAY-1:0] mispredict_i,
  output logic [NW-1:0]  n_rt_o,
  output logic           flush_pending_o
);

  logic stop;

  // Leading ready run, truncated after a mispredicted branch
  always_comb begin
    n_rt_o          = '0;
    flush_pending_o = 1'b0;
    stop            = 1'b0;
    for (int i = 0; i < WAY; i++) begin
      if (!stop && valid_i[i] && complete_i[i]) begin
        n_rt_o = NW'(i + 1);
        if (mispredict_i[i]) begin
          flush_pending_o = 1'b1;
          stop            = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer: WAY-wide dispatch and in-order retire,
// multi-port completion, precise flush on a retiring mispredict.
module rob_nway
  import rob_nway_pkg::*;
#(
  parameter  int ROB_SIZE       = 32,
  parameter  int WAY            = 2,
  parameter  int CDB_WIDTH      = 2,
  parameter  int AREG_IDX_WIDTH = 5,
  parameter  int PREG_IDX_WIDTH = 6,
  localparam int ROB_IDX_WIDTH  = $clog2(ROB_SIZE)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [WAY-1:0]                    dp_valid,
  input  logic [WAY*AREG_IDX_WIDTH-1:0]     dp_dest_areg,
  input  logic [WAY*PREG_IDX_WIDTH-1:0]     dp_dest_preg,
  input  logic [WAY*PREG_IDX_WIDTH-1:0]     dp_old_preg,
  output logic [WAY-1:0]                    dp_ack,
  output logic [WAY*ROB_IDX_WIDTH-1:0]      dp_rob_idx,
  output logic [ROB_IDX_WIDTH:0]            dp_free_cnt,
  output logic                              rob_almost_full,
  input  logic [CDB_WIDTH-1:0]              cdb_valid,
  input  logic [CDB_WIDTH*ROB_IDX_WIDTH-1:0] cdb_rob_idx,
  input  logic [CDB_WIDTH-1:0]              cdb_mispredict,
  input  logic [CDB_WIDTH*ROB_PC_W-1:0]     cdb_target_pc,
  output logic [WAY-1:0]                    rt_valid,
  output logic [WAY*AREG_IDX_WIDTH-1:0]     rt_dest_areg,
  output logic [WAY*PREG_IDX_WIDTH-1:0]     rt_dest_preg,
  output logic [WAY*PREG_IDX_WIDTH-1:0]     rt_old_preg,
  output logic                              flush,
  output logic [ROB_PC_W-1:0]               flush_pc
);

  localparam int IW = ROB_IDX_WIDTH;
  localparam int CW = IW + 1;
  localparam int NW = $clog2(WAY + 1);
  localparam int A  = AREG_IDX_WIDTH;
  localparam int P  = PREG_IDX_WIDTH;

  logic [ROB_SIZE-1:0] valid_q, valid_d;
  logic [ROB_SIZE-1:0] cmpl_q, cmpl_d;
  logic [ROB_SIZE-1:0] misp_q, misp_d;
  logic [ROB_PC_W-1:0] tpc_q  [ROB_SIZE];
  logic [ROB_PC_W-1:0] tpc_d  [ROB_SIZE];
  logic [A-1:0]        areg_q [ROB_SIZE];
  logic [A-1:0]        areg_d [ROB_SIZE];
  logic [P-1:0]        preg_q [ROB_SIZE];
  logic [P-1:0]        preg_d [ROB_SIZE];
  logic [P-1:0]        oldp_q [ROB_SIZE];
  logic [P-1:0]        oldp_d [ROB_SIZE];

  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, free_cnt;

  logic [WAY-1:0]   rt_valid_q, rt_valid_d;
  logic [WAY*A-1:0] rt_areg_q, rt_areg_d;
  logic [WAY*P-1:0] rt_preg_q, rt_preg_d;
  logic [WAY*P-1:0] rt_oldp_q, rt_oldp_d;
  logic             flush_q, flush_d;
  logic [ROB_PC_W-1:0] flush_pc_q, flush_pc_d;

  logic [IW-1:0]  hidx [WAY];
  logic [WAY-1:0] hv, hc, hm;
  logic [NW-1:0]  n_rt, n_dp;
  logic           flush_pending, ok;
  logic [IW-1:0]  br_idx;

  assign free_cnt        = CW'(ROB_SIZE) - count_q;
  assign dp_free_cnt     = free_cnt;
  assign rob_almost_full = free_cnt < CW'(WAY);
  assign br_idx          = head_q + IW'(n_rt) - IW'(1);

  // Gather the WAY oldest entries for the retire scan
  always_comb begin
    hv = '0;
    hc = '0;
    hm = '0;
    for (int i = 0; i < WAY; i++) begin
      hidx[i] = head_q + IW'(i);
      hv[i]   = valid_q[hidx[i]];
      hc[i]   = cmpl_q[hidx[i]];
      hm[i]   = misp_q[hidx[i]];
    end
  end

  rob_retire_sel #(
    .WAY (WAY)
  ) u_sel (
    .valid_i         (hv),
    .complete_i      (hc),
    .mispredict_i    (hm),
    .n_rt_o          (n_rt),
    .flush_pending_o (flush_pending)
  );

  // Dispatch acceptance: contiguous lanes that fit the free space
  always_comb begin
    ok         = 1'b1;
    n_dp       = '0;
    dp_ack     = '0;
    dp_rob_idx = '0;
    for (int i = 0; i < WAY; i++) begin
      ok        = ok & dp_valid[i] & (CW'(i) < free_cnt) & ~flush_pending;
      dp_ack[i] = ok;
      n_dp      = n_dp + NW'(ok);
      dp_rob_idx[i*IW +: IW] = tail_q + IW'(i);
    end
  end

  // Next state: retire, then completion, then dispatch (or flush)
  always_comb begin
    valid_d    = valid_q;
    cmpl_d     = cmpl_q;
    misp_d     = misp_q;
    tpc_d      = tpc_q;
    areg_d     = areg_q;
    preg_d     = preg_q;
    oldp_d     = oldp_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rt_valid_d = '0;
    rt_areg_d  = '0;
    rt_preg_d  = '0;
    rt_oldp_d  = '0;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;
    for (int i = 0; i < WAY; i++) begin
      if (NW'(i) < n_rt) begin
        rt_valid_d[i]        = 1'b1;
        rt_areg_d[i*A +: A]  = areg_q[hidx[i]];
        rt_preg_d[i*P +: P]  = preg_q[hidx[i]];
        rt_oldp_d[i*P +: P]  = oldp_q[hidx[i]];
      end
    end
    if (flush_pending) begin
      flush_d    = 1'b1;
      flush_pc_d = tpc_q[br_idx];
      valid_d    = '0;
      cmpl_d     = '0;
      misp_d     = '0;
      head_d     = br_idx + IW'(1);
      tail_d     = br_idx + IW'(1);
      count_d    = '0;
    end else begin
      for (int p = 0; p < CDB_WIDTH; p++) begin
        if (cdb_valid[p] && valid_q[cdb_rob_idx[p*IW +: IW]]) begin
          cmpl_d[cdb_rob_idx[p*IW +: IW]] = 1'b1;
          misp_d[cdb_rob_idx[p*IW +: IW]] = cdb_mispredict[p];
          tpc_d[cdb_rob_idx[p*IW +: IW]]  =
            cdb_target_pc[p*ROB_PC_W +: ROB_PC_W];
        end
      end
      for (int i = 0; i < WAY; i++) begin
        if (NW'(i) < n_rt) begin
          valid_d[hidx[i]] = 1'b0;
          cmpl_d[hidx[i]]  = 1'b0;
          misp_d[hidx[i]]  = 1'b0;
        end
      end
      for (int i = 0; i < WAY; i++) begin
        if (dp_ack[i]) begin
          valid_d[tail_q + IW'(i)] = 1'b1;
          cmpl_d[tail_q + IW'(i)]  = 1'b0;
          misp_d[tail_q + IW'(i)]  = 1'b0;
          areg_d[tail_q + IW'(i)]  = dp_dest_areg[i*A +: A];
          preg_d[tail_q + IW'(i)]  = dp_dest_preg[i*P +: P];
          oldp_d[tail_q + IW'(i)]  = dp_old_preg[i*P +: P];
        end
      end
      head_d  = head_q + IW'(n_rt);
      tail_d  = tail_q + IW'(n_dp);
      count_d = count_q + CW'(n_dp) - CW'(n_rt);
    end
  end

  // Control state and registered retire/flush outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      cmpl_q     <= '0;
      misp_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rt_valid_q <= '0;
      rt_areg_q  <= '0;
      rt_preg_q  <= '0;
      rt_oldp_q  <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      valid_q    <= valid_d;
      cmpl_q     <= cmpl_d;
      misp_q     <= misp_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rt_valid_q <= rt_valid_d;
      rt_areg_q  <= rt_areg_d;
      rt_preg_q  <= rt_preg_d;
      rt_oldp_q  <= rt_oldp_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Entry payload, qualified by the valid bits
  always_ff @(posedge clock) begin
    tpc_q  <= tpc_d;
    areg_q <= areg_d;
    preg_q <= preg_d;
    oldp_q <= oldp_d;
  end

  assign rt_valid     = rt_valid_q;
  assign rt_dest_areg = rt_areg_q;
  assign rt_dest_preg = rt_preg_q;
  assign rt_old_preg  = rt_oldp_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway (ROB_SIZE=8, WAY=2) against an in-order
// queue model of the ROB built from the retire/flush rules.
module tb_rob_nway;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  dp_valid = '0;
  logic [9:0]  dp_dest_areg = '0;
  logic [11:0] dp_dest_preg = '0;
  logic [11:0] dp_old_preg = '0;
  logic [1:0]  dp_ack;
  logic [5:0]  dp_rob_idx;
  logic [3:0]  dp_free_cnt;
  logic        rob_almost_full;
  logic [1:0]  cdb_valid = '0;
  logic [5:0]  cdb_rob_idx = '0;
  logic [1:0]  cdb_mispredict = '0;
  logic [63:0] cdb_target_pc = '0;
  logic [1:0]  rt_valid;
  logic [9:0]  rt_dest_areg;
  logic [11:0] rt_dest_preg;
  logic [11:0] rt_old_preg;
  logic        flush;
  logic [31:0] flush_pc;

  rob_nway #(
    .ROB_SIZE(8), .WAY(2), .CDB_WIDTH(2),
    .AREG_IDX_WIDTH(5), .PREG_IDX_WIDTH(6)
  ) dut (
    .clock(clock), .reset(reset),
    .dp_valid(dp_valid), .dp_dest_areg(dp_dest_areg),
    .dp_dest_preg(dp_dest_preg), .dp_old_preg(dp_old_preg),
    .dp_ack(dp_ack), .dp_rob_idx(dp_rob_idx),
    .dp_free_cnt(dp_free_cnt), .rob_almost_full(rob_almost_full),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
    .cdb_mispredict(cdb_mispredict), .cdb_target_pc(cdb_target_pc),
    .rt_valid(rt_valid), .rt_dest_areg(rt_dest_areg),
    .rt_dest_preg(rt_dest_preg), .rt_old_preg(rt_old_preg),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          idx;
    bit          c;
    bit          m;
    logic [31:0] pc;
    logic [4:0]  a;
    logic [5:0]  p;
    logic [5:0]  o;
  } ent_t;

  ent_t q[$];
  int   tail;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]  e_ack, o_ack, e_rtv;
  logic [2:0]  e_idx [2];
  logic [5:0]  o_idx;
  logic [3:0]  e_free, o_free;
  logic        e_af, o_af, e_flush;
  logic [31:0] e_fpc;
  logic [4:0]  e_ra [2];
  logic [5:0]  e_rp [2];
  logic [5:0]  e_ro [2];

  task automatic set_dp(input logic [1:0] v);
    dp_valid     = v;
    dp_dest_areg = 10'($urandom);
    dp_dest_preg = 12'($urandom);
    dp_old_preg  = 12'($urandom);
  endtask

  task automatic clr_cdb();
    cdb_valid      = '0;
    cdb_mispredict = '0;
  endtask

  task automatic set_cdb(input int port, input int idx,
                         input bit m, input logic [31:0] pc);
    cdb_valid[port]               = 1'b1;
    cdb_rob_idx[port*3 +: 3]      = 3'(idx);
    cdb_mispredict[port]          = m;
    cdb_target_pc[port*32 +: 32]  = pc;
  endtask

  // One clock of the reference model; leaves time at posedge+1
  task automatic cyc();
    int free, nrt, nack;
    bit fp, ok;
    ent_t e;
    #1;
    free = 8 - q.size();
    nrt  = 0;
    fp   = 0;
    for (int i = 0; i < 2; i++) begin
      if (i >= q.size() || !q[i].c) break;
      nrt = i + 1;
      if (q[i].m) begin
        fp = 1;
        break;
      end
    end
    ok   = 1;
    nack = 0;
    for (int i = 0; i < 2; i++) begin
      ok       = ok && dp_valid[i] && (i < free) && !fp;
      e_ack[i] = ok;
      if (ok) nack++;
      e_idx[i] = 3'((tail + i) % 8);
    end
    e_free = 4'(free);
    e_af   = free < 2;
    o_ack  = dp_ack;
    o_idx  = dp_rob_idx;
    o_free = dp_free_cnt;
    o_af   = rob_almost_full;
    @(posedge clock);
    e_rtv   = '0;
    e_flush = 1'b0;
    for (int i = 0; i < nrt; i++) begin
      e_rtv[i] = 1'b1;
      e_ra[i]  = q[i].a;
      e_rp[i]  = q[i].p;
      e_ro[i]  = q[i].o;
    end
    if (fp) begin
      e_flush = 1'b1;
      e_fpc   = q[nrt-1].pc;
      tail    = (q[nrt-1].idx + 1) % 8;
      q.delete();
    end else begin
      repeat (nrt) void'(q.pop_front());
      for (int p = 0; p < 2; p++) begin
        if (cdb_valid[p]) begin
          foreach (q[k]) begin
            if (q[k].idx == int'(cdb_rob_idx[p*3 +: 3])) begin
              q[k].c  = 1'b1;
              q[k].m  = cdb_mispredict[p];
              q[k].pc = cdb_target_pc[p*32 +: 32];
            end
          end
        end
      end
      for (int i = 0; i < nack; i++) begin
        e.idx = (tail + i) % 8;
        e.c   = 0;
        e.m   = 0;
        e.pc  = '0;
        e.a   = dp_dest_areg[i*5 +: 5];
        e.p   = dp_dest_preg[i*6 +: 6];
        e.o   = dp_old_preg[i*6 +: 6];
        q.push_back(e);
      end
      tail = (tail + nack) % 8;
    end
    #1;
  endtask

  // Complete outstanding entries two per cycle until empty
  task automatic drain();
    for (int n = 0; n < 20 && q.size() != 0; n++) begin
      set_dp(2'b00);
      clr_cdb();
      for (int k = 0, p = 0; k < q.size() && p < 2; k++) begin
        if (!q[k].c) begin
          set_cdb(p, q[k].idx, 1'b0, 32'h0);
          p++;
        end
      end
      cyc();
    end
    clr_cdb();
    cyc();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (rt_valid !== 2'b00 || flush !== 1'b0 || flush_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: rt_valid=%b flush=%b pc=%h req 00/0/0",
               rt_valid, flush, flush_pc);
    end
    checks++;
    if (dp_free_cnt !== 4'd8 || rob_almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_free: free=%0d af=%b req 8/0",
               dp_free_cnt, rob_almost_full);
    end
    checks++;
    if (dp_rob_idx !== 6'b001_000) begin
      errors++;
      $display("FAIL reset_idx: got %b req 001000", dp_rob_idx);
    end
  endtask

  task automatic test_fill();
    logic [3:0] fr;
    for (int c = 0; c < 5; c++) begin
      set_dp(2'b11);
      clr_cdb();
      cyc();
      fr = 4'(8 - 2 * c);
      checks++;
      if (o_ack !== e_ack || o_ack !== ((c < 4) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL fill_ack c%0d: got %b req %b", c, o_ack, e_ack);
      end
      checks++;
      if (o_free !== e_free || o_free !== fr) begin
        errors++;
        $display("FAIL fill_free c%0d: got %0d req %0d", c, o_free, fr);
      end
      checks++;
      if (o_idx !== {e_idx[1], e_idx[0]}) begin
        errors++;
        $display("FAIL fill_idx c%0d: got %b req %0d/%0d",
                 c, o_idx, e_idx[1], e_idx[0]);
      end
      checks++;
      if (o_af !== e_af || o_af !== (c == 4)) begin
        errors++;
        $display("FAIL fill_af c%0d: got %b req %b", c, o_af, e_af);
      end
    end
  endtask

  task automatic test_complete_order();
    set_dp(2'b00);
    clr_cdb();
    set_cdb(0, 1, 1'b0, 32'h0);
    cyc();
    clr_cdb();
    set_cdb(0, 0, 1'b0, 32'h0);
    cyc();
    checks++;
    if (rt_valid !== 2'b00) begin
      errors++;
      $display("FAIL order_hold: rt_valid=%b req 00", rt_valid);
    end
    clr_cdb();
    cyc();
    checks++;
    if (rt_valid !== 2'b11 || e_rtv !== 2'b11 ||
        rt_dest_areg !== {e_ra[1], e_ra[0]} ||
        rt_old_preg !== {e_ro[1], e_ro[0]}) begin
      errors++;
      $display("FAIL order_rt: v=%b a=%h o=%h req 11 a=%h%h o=%h%h",
               rt_valid, rt_dest_areg, rt_old_preg,
               e_ra[1], e_ra[0], e_ro[1], e_ro[0]);
    end
    cyc();
    checks++;
    if (o_free !== 4'd2) begin
      errors++;
      $display("FAIL order_free: got %0d req 2", o_free);
    end
    drain();
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 3; c++) begin
      set_dp(2'b11);
      cyc();
    end
    drain();
    set_dp(2'b11);
    cyc();
    checks++;
    if (o_idx !== 6'b111_110) begin
      errors++;
      $display("FAIL wrap_idx0: got %b req 111110", o_idx);
    end
    cyc();
    checks++;
    if (o_idx !== 6'b001_000) begin
      errors++;
      $display("FAIL wrap_idx1: got %b req 001000", o_idx);
    end
    set_dp(2'b00);
    set_cdb(0, 6, 1'b0, 32'h0);
    set_cdb(1, 7, 1'b0, 32'h0);
    cyc();
    set_cdb(0, 0, 1'b0, 32'h0);
    set_cdb(1, 1, 1'b0, 32'h0);
    cyc();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (rt_valid !== 2'b11 || rt_dest_preg !== {e_rp[1], e_rp[0]}) begin
        errors++;
        $display("FAIL wrap_rt%0d: v=%b p=%h req 11 p=%h%h",
                 c, rt_valid, rt_dest_preg, e_rp[1], e_rp[0]);
      end
      clr_cdb();
      cyc();
    end
    checks++;
    if (rt_valid !== 2'b00 || o_free !== 4'd8 || o_idx !== 6'b011_010) begin
      errors++;
      $display("FAIL wrap_end: v=%b free=%0d idx=%b req 00/8/011010",
               rt_valid, o_free, o_idx);
    end
  endtask

  task automatic test_mispredict();
    int t;
    t = tail;
    for (int c = 0; c < 3; c++) begin
      set_dp(2'b11);
      cyc();
    end
    set_dp(2'b00);
    set_cdb(0, t, 1'b0, 32'h0);
    set_cdb(1, (t + 1) % 8, 1'b0, 32'h0);
    cyc();
    clr_cdb();
    set_cdb(0, (t + 2) % 8, 1'b1, 32'h1000);
    cyc();
    checks++;
    if (rt_valid !== 2'b11 || flush !== 1'b0) begin
      errors++;
      $display("FAIL misp_a: v=%b flush=%b req 11/0", rt_valid, flush);
    end
    clr_cdb();
    set_cdb(0, (t + 3) % 8, 1'b0, 32'h0);
    set_dp(2'b11);
    cyc();
    checks++;
    if (o_ack !== 2'b00) begin
      errors++;
      $display("FAIL misp_block: ack=%b req 00", o_ack);
    end
    checks++;
    if (rt_valid !== 2'b01 || flush !== 1'b1 || flush_pc !== 32'h1000 ||
        rt_dest_areg[4:0] !== e_ra[0]) begin
      errors++;
      $display("FAIL misp_b: v=%b flush=%b pc=%h req 01/1/00001000",
               rt_valid, flush, flush_pc);
    end
    clr_cdb();
    set_dp(2'b00);
    cyc();
    checks++;
    if (flush !== 1'b0 || o_free !== 4'd8 || rt_valid !== 2'b00 ||
        o_idx !== {3'((t + 4) % 8), 3'((t + 3) % 8)}) begin
      errors++;
      $display("FAIL misp_after: flush=%b free=%0d v=%b idx=%b",
               flush, o_free, rt_valid, o_idx);
    end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < 4; c++) begin
      set_dp(c < 3 ? 2'b11 : 2'b01);
      cyc();
    end
    set_dp(2'b00);
    set_cdb(0, q[0].idx, 1'b0, 32'h0);
    set_cdb(1, q[1].idx, 1'b0, 32'h0);
    cyc();
    clr_cdb();
    set_dp(2'b11);
    cyc();
    checks++;
    if (o_ack !== 2'b01 || o_free !== 4'd1) begin
      errors++;
      $display("FAIL simul_ack: ack=%b free=%0d req 01/1", o_ack, o_free);
    end
    set_dp(2'b00);
    cyc();
    checks++;
    if (o_free !== 4'd2 || rt_valid !== 2'b00) begin
      errors++;
      $display("FAIL simul_cnt: free=%0d v=%b req 2/00", o_free, rt_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    set_dp(2'b11);
    cyc();
    set_dp(2'b00);
    set_cdb(0, q[0].idx, 1'b0, 32'h0);
    set_cdb(1, q[1].idx, 1'b0, 32'h0);
    cyc();
    clr_cdb();
    cyc();
    checks++;
    if (rt_valid !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_pre: v=%b req 11", rt_valid);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (rt_valid !== 2'b00 || flush !== 1'b0 || dp_free_cnt !== 4'd8) begin
      errors++;
      $display("FAIL rstmid_async: v=%b flush=%b free=%0d req 00/0/8",
               rt_valid, flush, dp_free_cnt);
    end
    q.delete();
    tail = 0;
    @(negedge clock);
    #1 reset = 1'b1;
    set_dp(2'b11);
    cyc();
    checks++;
    if (o_idx !== 6'b001_000 || o_free !== 4'd8 || o_ack !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_post: idx=%b free=%0d ack=%b req 001000/8/11",
               o_idx, o_free, o_ack);
    end
  endtask

  task automatic test_random();
    int r, pick, c0;
    int cand[$];
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 7);
      set_dp(r < 2 ? 2'b00 : r < 4 ? 2'b01 : r < 7 ? 2'b11 : 2'b10);
      clr_cdb();
      c0 = -1;
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) == 0) continue;
        cand.delete();
        foreach (q[k]) if (!q[k].c && q[k].idx != c0) cand.push_back(q[k].idx);
        if (cand.size() != 0 && $urandom_range(0, 7) != 0) begin
          pick = cand[$urandom_range(0, cand.size() - 1)];
        end else begin
          if (q.size() == 8) continue;
          pick = (tail + q.size() + $urandom_range(0, 7 - q.size())) % 8;
          if (pick == c0) continue;
        end
        set_cdb(p, pick, $urandom_range(0, 15) == 0, $urandom);
        c0 = pick;
      end
      cyc();
      checks++;
      if (o_ack !== e_ack || o_idx !== {e_idx[1], e_idx[0]} ||
          o_free !== e_free || o_af !== e_af) begin
        errors++;
        $display("FAIL rnd_dp n%0d: ack=%b idx=%b free=%0d af=%b req %b %0d/%0d %0d %b",
                 n, o_ack, o_idx, o_free, o_af,
                 e_ack, e_idx[1], e_idx[0], e_free, e_af);
      end
      checks++;
      if (rt_valid !== e_rtv || flush !== e_flush ||
          (e_flush && flush_pc !== e_fpc)) begin
        errors++;
        $display("FAIL rnd_rt n%0d: v=%b flush=%b pc=%h req %b %b %h",
                 n, rt_valid, flush, flush_pc, e_rtv, e_flush, e_fpc);
      end
      for (int i = 0; i < 2; i++) begin
        if (e_rtv[i]) begin
          checks++;
          if (rt_dest_areg[i*5 +: 5] !== e_ra[i] ||
              rt_dest_preg[i*6 +: 6] !== e_rp[i] ||
              rt_old_preg[i*6 +: 6] !== e_ro[i]) begin
            errors++;
            $display("FAIL rnd_data n%0d l%0d: a=%h p=%h o=%h req %h %h %h",
                     n, i, rt_dest_areg[i*5 +: 5], rt_dest_preg[i*6 +: 6],
                     rt_old_preg[i*6 +: 6], e_ra[i], e_rp[i], e_ro[i]);
          end
        end
      end
    end
  endtask

  initial begin
    tail = 0;
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
    test_reset();
    test_fill();
    test_complete_order();
    test_wrap();
    test_mispredict();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
